shift_line_arbiter: RTL and testbench

- Round-robin scheduler that shares one N-stage serial shift/pair-detect line between NREQ requesters.
- Grants one requester at a time and clears the line. It then serializes the requester's W-bit word into the line MSB-first and flushes the line with N zeros.
- During shift and flush it records whether the line's pair-detect flag ever asserted, and returns that result to the requester with a done pulse.
- Sits between the player input logic and the shared detect line.

---
 rtl/shift_line_arbiter_pkg.sv | 20 ++
 rtl/shift_line_arbiter_if.sv | 25 ++
 rtl/shift_line_arbiter_rr_arbiter.sv | 28 ++
 rtl/shift_line_arbiter.sv | 106 ++++++++++
 tb/tb_shift_line_arbiter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/shift_line_arbiter_pkg.sv
// shift_line_arbiter_pkg: shared state encoding, default sizes and helpers
package shift_line_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        FLUSH,
        REPORT
    } state_e;

    localparam int N_DEF    = 64;
    localparam int W_DEF    = 8;
    localparam int NREQ_DEF = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/shift_line_arbiter_if.sv
// shift_line_arbiter_if: requester handshake plus shared shift-line connection
interface shift_line_arbiter_if #(
    parameter int NREQ = 2,
    parameter int W    = 8
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_word;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic              hit;
    logic              busy;
    logic              sr_clr;
    logic              sr_in;
    logic              sr_on;

    modport slave (
        input  req, req_word, sr_on,
        output grant, done, hit, busy, sr_clr, sr_in
    );

    modport master (
        output req, req_word, sr_on,
        input  grant, done, hit, busy, sr_clr, sr_in
    );
endinterface

// File: rtl/shift_line_arbiter_rr_arbiter.sv
// rr_arbiter: first requester at or above the pointer, wrapping around
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o
);
    logic found;
    int   j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr_i) + k) % NREQ;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end
endmodule

// File: rtl/shift_line_arbiter.sv
// shift_line_arbiter: round-robin owner of a shared serial pair-detect line;
// each grant clears the line, shifts one word in MSB-first, flushes, reports hit.
module shift_line_arbiter
    import shift_line_arbiter_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int W    = W_DEF,
    parameter int NREQ = NREQ_DEF
) (
    input logic                   clk,
    input logic                   reset,
    shift_line_arbiter_if.slave   bus
);
    localparam int CW = $clog2(max_int(W, N) + 1);
    localparam int IW = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   ptr_q, ptr_d, own_q, own_d, win_idx;
    logic [NREQ-1:0] win_oh, grant_q, grant_d;
    logic [W-1:0]    word_q, word_d, word_sh;
    logic            acc_q, acc_d;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .gnt_o (win_oh),
        .idx_o (win_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            own_q   <= '0;
            grant_q <= '0;
            word_q  <= '0;
            acc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            grant_q <= grant_d;
            word_q  <= word_d;
            acc_q   <= acc_d;
        end
    end

    // The grant cycle stays in IDLE so grant is a registered pulse one cycle ahead of CLEAR.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        grant_d = '0;
        word_d  = word_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (|grant_q) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (|bus.req) begin
                    grant_d = win_oh;
                    own_d   = win_idx;
                    word_d  = bus.req_word[win_idx*W +: W];
                    acc_d   = 1'b0;
                    ptr_d   = (int'(win_idx) == NREQ - 1) ? '0 : IW'(int'(win_idx) + 1);
                end
            end
            CLEAR: begin
                state_d = SHIFT;
                cnt_d   = CW'(W - 1);
            end
            SHIFT: begin
                acc_d   = acc_q | bus.sr_on;
                state_d = (cnt_q == '0) ? FLUSH : SHIFT;
                cnt_d   = (cnt_q == '0) ? CW'(N - 1) : cnt_q - CW'(1);
            end
            FLUSH: begin
                acc_d   = acc_q | bus.sr_on;
                state_d = (cnt_q == '0) ? REPORT : FLUSH;
                cnt_d   = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
            end
            REPORT: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign word_sh    = word_q >> cnt_q;
    assign bus.grant  = grant_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.sr_clr = (state_q == CLEAR);
    assign bus.sr_in  = (state_q == SHIFT) & word_sh[0];
    assign bus.done   = (state_q == REPORT) ? (ONE << own_q) : '0;
    assign bus.hit    = (state_q == REPORT) & acc_q;
endmodule

// File: tb/tb_shift_line_arbiter.sv
// tb_shift_line_arbiter: vector table, corner sequences and random traffic
// against a pair-detect line model and a rule-level arbitration model.
module tb_shift_line_arbiter;
    import shift_line_arbiter_pkg::*;

    localparam int N    = 64;
    localparam int W    = 8;
    localparam int NREQ = 2;

    typedef struct {
        logic [NREQ-1:0] r;
        logic [W-1:0]    w0;
        logic [W-1:0]    w1;
        int              idx;
        logic            hit;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic [N-1:0] line = '0;
    int checks = 0;
    int errors = 0;
    int mptr = 0;
    int wait_n = 0;
    vec_t tbl[8];

    always #5 clk = ~clk;

    shift_line_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    shift_line_arbiter #(.N(N), .W(W), .NREQ(NREQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Environment: the shared line itself, with an adjacent-ones detector.
    always @(posedge clk) line <= bus.sr_clr ? '0 : {line[N-2:0], bus.sr_in};
    assign bus.sr_on = |(line & (line >> 1));

    function automatic logic pair_hit(input logic [W-1:0] w);
        return |(w & (w >> 1));
    endfunction

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_grant"}, bus.grant, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_hit"}, bus.hit, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_sr_clr"}, bus.sr_clr, 0);
        chk({tag, "_sr_in"}, bus.sr_in, 0);
    endtask

    task automatic do_reset;
        reset = 1'b0;
        bus.req = '0;
        repeat (3) tick;
        reset = 1'b1;
        mptr = 0;
    endtask

    task automatic run_txn(input logic [NREQ-1:0] r, input logic [W-1:0] w0, input logic [W-1:0] w1,
                           input int exp_idx, input logic exp_hit, input bit drop);
        logic [W-1:0] w;
        int n;
        bit seen;
        w = (exp_idx == 0) ? w0 : w1;
        bus.req = r;
        bus.req_word = {w1, w0};
        seen = 0;
        wait_n = 0;
        while (!seen && wait_n < 200) begin
            tick;
            wait_n++;
            seen = |bus.grant;
        end
        chk("grant_seen", 32'(seen), 1);
        if (!seen) return;
        chk("grant", bus.grant, 1 << exp_idx);
        chk("busy_at_grant", bus.busy, 0);
        chk("hit_at_grant", bus.hit, 0);
        mptr = (exp_idx + 1) % NREQ;
        bus.req_word = {$urandom, $urandom};
        if (drop) bus.req = '0;
        tick;
        chk("sr_clr", bus.sr_clr, 1);
        chk("busy_clear", bus.busy, 1);
        chk("sr_in_clear", bus.sr_in, 0);
        for (int k = 0; k < W; k++) begin
            tick;
            chk("sr_in", bus.sr_in, w[W-1-k]);
        end
        n = 1 + W;
        seen = 0;
        while (!seen && n < 200) begin
            tick;
            n++;
            seen = |bus.done;
        end
        chk("latency", n, W + N + 2);
        chk("done", bus.done, 1 << exp_idx);
        chk("hit", bus.hit, exp_hit);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int ix;
        bit seen;
        logic [NREQ-1:0] r;
        logic [W-1:0] w0, w1;
        tbl[0] = '{2'b01, 8'hAA, 8'h00, 0, 1'b0};
        tbl[1] = '{2'b10, 8'h00, 8'h18, 1, 1'b1};
        tbl[2] = '{2'b11, 8'hFF, 8'h81, 0, 1'b1};
        tbl[3] = '{2'b11, 8'h00, 8'h81, 1, 1'b0};
        tbl[4] = '{2'b10, 8'h00, 8'h03, 1, 1'b1};
        tbl[5] = '{2'b11, 8'h81, 8'hFF, 0, 1'b0};
        tbl[6] = '{2'b01, 8'hC0, 8'h00, 0, 1'b1};
        tbl[7] = '{2'b11, 8'h01, 8'h80, 1, 1'b0};

        reset = 1'b0;
        bus.req = '0;
        bus.req_word = '0;
        tick;
        tick;
        chk_quiet("rst");
        reset = 1'b1;
        repeat (3) tick;
        chk_quiet("idle");

        foreach (tbl[i]) run_txn(tbl[i].r, tbl[i].w0, tbl[i].w1, tbl[i].idx, tbl[i].hit, 1'b1);

        do_reset;
        run_txn(2'b11, 8'hAA, 8'h18, 0, 1'b0, 1'b0);
        chk("first_grant_wait", wait_n, 1);
        for (int i = 1; i < 4; i++) begin
            run_txn(2'b11, 8'hAA, 8'h18, i % 2, (i % 2) == 1, 1'b0);
            chk("regrant_wait", wait_n, 2);
        end

        bus.req = 2'b01;
        bus.req_word = {8'h00, 8'hFF};
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick;
            seen = |bus.grant;
        end
        chk("abort_grant", bus.grant, 2'b01);
        repeat (5) tick;
        reset = 1'b0;
        #1;
        chk_quiet("abort");
        repeat (3) begin
            tick;
            chk("abort_done", bus.done, 0);
        end
        reset = 1'b1;
        mptr = 0;
        run_txn(2'b01, 8'hAA, 8'h00, 0, 1'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            r = NREQ'($urandom_range(1, 3));
            w0 = W'($urandom);
            w1 = W'($urandom);
            ix = pick(r, mptr);
            run_txn(r, w0, w1, ix, pair_hit(ix == 0 ? w0 : w1), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
